// File: rtl/mem_sweep_checker_if.sv
// Host/RAM-side bundle for the memory sweep checker: start/stall control,
// RAM read address and data, and the sweep status and results.
interface mem_sweep_checker_if #(
  parameter int WID_MEM = 9
);
  logic               start;
  logic               stall;
  logic [12:0]        raddr;
  logic [WID_MEM-1:0] rdata;
  logic               busy;
  logic               done;
  logic [31:0]        signature;
  logic [31:0]        ones;

  // Host side: drives control and returns RAM read data.
  modport master (
    output start, stall, rdata,
    input  raddr, busy, done, signature, ones
  );

  // Checker side.
  modport slave (
    input  start, stall, rdata,
    output raddr, busy, done, signature, ones
  );
endinterface

// File: rtl/mem_sweep_checker.sv
// Sweeps every RAM word in address order, absorbs the 1-cycle registered
// read data, and folds each word into a rotate-XOR signature and a
// running ones-count for post-init content verification.
module mem_sweep_checker #(
  parameter int          WID_MEM   = 9,
  parameter int          DEPTH_MEM = 8192,
  parameter logic [31:0] SEED      = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              reset,
  mem_sweep_checker_if.slave bus
);

  typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_t;

  localparam logic [12:0] LAST = 13'(DEPTH_MEM - 1);

  state_t      state;
  logic [12:0] raddr;
  logic        rd_vld;
  logic        busy;
  logic        done;
  logic [31:0] signature;
  logic [31:0] ones;
  logic [31:0] sig_next;
  logic [31:0] ones_next;

  function automatic logic [5:0] popcount(input logic [WID_MEM-1:0] v);
    logic [5:0] c;
    c = '0;
    for (int unsigned i = 0; i < WID_MEM; i++) c = c + 6'(v[i]);
    return c;
  endfunction

  // Fold of the word currently on rdata into the running results.
  always_comb begin
    sig_next  = {signature[30:0], signature[31]} ^ 32'(bus.rdata);
    ones_next = ones + 32'(popcount(bus.rdata));
  end

  // Sweep FSM with address issue, data capture and registered status.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      raddr     <= '0;
      rd_vld    <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      signature <= SEED;
      ones      <= '0;
    end else begin
      // rd_vld marks that the RAM sampled a real issue on the previous edge.
      if (rd_vld) begin
        signature <= sig_next;
        ones      <= ones_next;
      end
      case (state)
        IDLE, DONE: begin
          if (bus.start) begin
            state     <= SCAN;
            raddr     <= '0;
            signature <= SEED;
            ones      <= '0;
            rd_vld    <= 1'b0;
            busy      <= 1'b1;
            done      <= 1'b0;
          end
        end
        SCAN: begin
          if (!bus.stall) begin
            rd_vld <= 1'b1;
            if (raddr == LAST) state <= DRAIN;
            else               raddr <= raddr + 13'd1;
          end else begin
            rd_vld <= 1'b0;
          end
        end
        DRAIN: begin
          if (rd_vld) begin
            state  <= DONE;
            rd_vld <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.raddr     = raddr;
  assign bus.busy      = busy;
  assign bus.done      = done;
  assign bus.signature = signature;
  assign bus.ones      = ones;

endmodule
